brick_drawer: RTL and testbench
===============================

// Module: brick_drawer
// PURPOSE
//  Sweeps every brick slot of the brick grid after a start pulse. Reads each slot's colour from brick RAM and gets the
//  slot's top-left pixel from address_xy (address_in -> x_out/y_out). Emits one VGA plot request per brick pixel.
//  Sits between brick RAM/address_xy and the VGA adapter write port; the top-level FSM starts it after brick changes.
// PARAMETERS
//  GRIDX   16  bricks per row (must match address_xy)
//  GRIDY   8   brick rows; NUM_BRICKS = GRIDX*GRIDY, must be <= 1024
//  BRICKX  8   brick width in pixels
//  BRICKY  4   brick height in pixels
// PORTS
//  clock     in   1   single system clock; all state changes on posedge
//  resetn    in   1   synchronous, active-low reset
//  start     in   1   one-cycle pulse; begins a sweep when idle
//  mem_addr  out  10  brick RAM read address (= current slot index)
//  mem_q     in   3   brick RAM data, valid 1 cycle after mem_addr; 3'b000 = no brick
//  xy_addr   out  10  to address_xy.address_in (= current slot index)
//  base_x    in   10  from address_xy.x_out, combinational from xy_addr
//  base_y    in   10  from address_xy.y_out
//  x         out  10  pixel x to VGA adapter
//  y         out  10  pixel y to VGA adapter
//  colour    out  3   pixel colour to VGA adapter
//  plot      out  1   VGA write enable; one pixel per high cycle
//  busy      out  1   high from the cycle after accepted start until done
//  done      out  1   one-cycle pulse after the final slot
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state=IDLE, slot=0, px=py=0, all outputs 0. Applies mid-sweep; the sweep is abandoned.
//  States:
//   IDLE   - start=1 -> FETCH, slot<=0. start ignored in every other state.
//   FETCH  - mem_addr/xy_addr = slot. 1 cycle -> LATCH.
//   LATCH  - capture col_q<=mem_q, bx_q<=base_x, by_q<=base_y, px=py=0.
//            col_q!=0 -> DRAW. col_q==0 -> NEXT (see optional feature).
//   DRAW   - plot=1, x=bx_q+px, y=by_q+py, colour=col_q. Exactly 1 pixel per cycle.
//            px increments 0..BRICKX-1; on wrap, px<=0 and py++. After (BRICKX-1,BRICKY-1) -> NEXT.
//            Duration: BRICKX*BRICKY cycles. Raster order: row-major within the brick.
//   NEXT   - slot==NUM_BRICKS-1 -> DONE; otherwise slot++ -> FETCH.
//   DONE   - done=1 for 1 cycle, busy=0 -> IDLE.
//  Cycle counts: drawn brick = 3+BRICKX*BRICKY cycles (FETCH+LATCH+DRAW+NEXT); skipped brick = 3 cycles.
//  Full sweep: sum of per-slot cycles, plus 1 DONE cycle.
//  Outputs outside DRAW: plot=0. x/y/colour hold their last values (don't-care to the VGA adapter).
//  busy=1 in FETCH/LATCH/DRAW/NEXT.
//  Arithmetic: x/y adds are 10-bit unsigned, wrap mod 1024 (not reachable with default parameters).
//   slot counter is 10 bits and never exceeds NUM_BRICKS-1.
//  mem_addr and xy_addr are driven from the same slot register. mem_q is sampled only in LATCH.
//  Brick RAM may change mid-sweep. Each slot uses the value read at its own LATCH.
// CONFIGURATION
//  ERASE_EMPTY_EN defined: empty slots (col_q==0) also go to DRAW.
//   They plot BRICKX*BRICKY pixels of colour 3'b000, erasing destroyed bricks.
//   Full sweep is always NUM_BRICKS*(3+BRICKX*BRICKY)+1 cycles.
//  ERASE_EMPTY_EN undefined: empty slots are skipped. No plot pulses; 3 cycles per empty slot.
// TESTING
//  1 Reset: resetn=0 during DRAW of slot 5 -> next cycle plot=0, busy=0, done=0, state IDLE.
//     A following start restarts at slot 0.
//  2 Single brick: only slot 17 = 3'b100, start -> 32 plots.
//     x 8..15 by y 4..7, row-major, colour 3'b100. done exactly 128*3+32+1 cycles after start (macro off).
//  3 Empty grid, macro off -> zero plot cycles; done pulses once; busy high for 384 cycles.
//  4 Empty grid, ERASE_EMPTY_EN on -> 4096 plots, all colour 0.
//     Last pixel is (127,31); done 128*35+1 cycles after start.
//  5 start re-pulsed while busy (e.g. cycle 10) -> ignored. Sweep and done timing identical to test 2.
//  6 Full grid, slot 127 colour 3'b011 -> final plot at x=127,y=31, colour 3'b011.
//     done asserts the cycle after NEXT of slot 127.

Source files
------------

// File: rtl/brick_drawer.sv
// Brick grid sweeper: walks every slot, reads its colour and base pixel, and emits one plot per
// brick pixel. Define ERASE_EMPTY_EN to also paint empty slots in colour 0.
module brick_drawer #(
    parameter int unsigned GRIDX  = 16,
    parameter int unsigned GRIDY  = 8,
    parameter int unsigned BRICKX = 8,
    parameter int unsigned BRICKY = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    output logic [9:0] mem_addr,
    input  logic [2:0] mem_q,
    output logic [9:0] xy_addr,
    input  logic [9:0] base_x,
    input  logic [9:0] base_y,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int unsigned NumBricks = GRIDX * GRIDY;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StDraw,
        StNext,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [9:0] slot_q;
    logic [9:0] px_q, py_q;
    logic [9:0] bx_q, by_q;
    logic [2:0] col_q;
    logic [9:0] x_hold_q, y_hold_q;
    logic [2:0] colour_hold_q;

    logic px_last, py_last, last_slot;

    assign px_last   = (px_q == 10'(BRICKX - 1));
    assign py_last   = (py_q == 10'(BRICKY - 1));
    assign last_slot = (slot_q == 10'(NumBricks - 1));

    assign mem_addr = slot_q;
    assign xy_addr  = slot_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StFetch;
            StFetch: state_d = StLatch;
`ifdef ERASE_EMPTY_EN
            StLatch: state_d = StDraw;
`else
            // mem_q is the value being captured into col_q this same edge
            StLatch: state_d = (mem_q != 3'b000) ? StDraw : StNext;
`endif
            StDraw:  if (px_last && py_last) state_d = StNext;
            StNext:  state_d = last_slot ? StDone : StFetch;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            slot_q        <= '0;
            px_q          <= '0;
            py_q          <= '0;
            bx_q          <= '0;
            by_q          <= '0;
            col_q         <= '0;
            x_hold_q      <= '0;
            y_hold_q      <= '0;
            colour_hold_q <= '0;
        end else begin
            // Pixel outputs keep their last driven value between DRAW bursts
            x_hold_q      <= x;
            y_hold_q      <= y;
            colour_hold_q <= colour;
            case (state_q)
                StIdle: begin
                    if (start) slot_q <= '0;
                end
                StLatch: begin
                    col_q <= mem_q;
                    bx_q  <= base_x;
                    by_q  <= base_y;
                    px_q  <= '0;
                    py_q  <= '0;
                end
                StDraw: begin
                    if (px_last) begin
                        px_q <= '0;
                        py_q <= py_q + 10'd1;
                    end else begin
                        px_q <= px_q + 10'd1;
                    end
                end
                StNext: begin
                    if (!last_slot) slot_q <= slot_q + 10'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        plot   = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        x      = x_hold_q;
        y      = y_hold_q;
        colour = colour_hold_q;
        unique case (state_q)
            StIdle: ;
            StFetch, StLatch, StNext: busy = 1'b1;
            StDraw: begin
                busy   = 1'b1;
                plot   = 1'b1;
                x      = bx_q + px_q;
                y      = by_q + py_q;
                colour = col_q;
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_brick_drawer.sv
// Scoreboard bench for brick_drawer: expected pixels are queued at start, popped on each plot.
module tb_brick_drawer;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [9:0] mem_addr, xy_addr, base_x, base_y, x, y;
    logic [2:0] mem_q, colour;
    logic       plot, busy, done;

    logic [2:0]  ram [1024];
    logic [22:0] exp_q [$];
    int checks   = 0;
    int failures = 0;

    brick_drawer dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_q    (mem_q),
        .xy_addr  (xy_addr),
        .base_x   (base_x),
        .base_y   (base_y),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    // Synchronous-read brick RAM and combinational address_xy
    always @(posedge clock) mem_q <= ram[mem_addr];
    assign base_x = (xy_addr % 10'd16) * 10'd8;
    assign base_y = (xy_addr / 10'd16) * 10'd4;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (plot) begin
            check_eq("pix_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("pix", 32'({x, y, colour}), 32'(exp_q.pop_front()));
        end
    end

    task automatic build_expect(output int cycles, output int plots);
        cycles = 1;
        plots  = 0;
        for (int s = 0; s < 128; s++) begin
            logic [2:0] c;
            logic [9:0] bx, by;
            bit drawn;
            c  = ram[s];
            bx = 10'((s % 16) * 8);
            by = 10'((s / 16) * 4);
            drawn = (c != 3'b000);
`ifdef ERASE_EMPTY_EN
            drawn = 1'b1;
`endif
            if (drawn) begin
                cycles += 35;
                plots  += 32;
                for (int py = 0; py < 4; py++)
                    for (int px = 0; px < 8; px++)
                        exp_q.push_back({bx + 10'(px), by + 10'(py), c});
            end else begin
                cycles += 3;
            end
        end
    endtask

    // Returns at the negedge of the first cycle after the accepting edge
    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_sweep(input string name, input int restart_at, output logic [22:0] last_pix);
        int exp_cycles, exp_plots, cnt, nplot, nbusy, done_at;
        build_expect(exp_cycles, exp_plots);
        pulse_start();
        check_eq({name, "_fetch_slot0"}, 32'(mem_addr), 32'd0);
        cnt = 1; nplot = 0; nbusy = 0; done_at = 0; last_pix = '0;
        while (done_at == 0 && cnt < 10000) begin
            if (plot) begin
                nplot++;
                last_pix = {x, y, colour};
            end
            if (busy) nbusy++;
            if (done) begin
                done_at = cnt;
            end else begin
                if (cnt == restart_at) start = 1'b1;
                @(negedge clock);
                start = 1'b0;
                cnt++;
            end
        end
        check_eq({name, "_done_cycle"}, 32'(done_at), 32'(exp_cycles));
        check_eq({name, "_plots"}, 32'(nplot), 32'(exp_plots));
        check_eq({name, "_busy_cycles"}, 32'(nbusy), 32'(exp_cycles - 1));
        check_eq({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        @(negedge clock);
        check_eq({name, "_done_pulse"}, 32'({done, busy, plot}), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [22:0] last;
        int dc, dp, cnt;
        resetn = 1'b0;
        start  = 1'b0;
        for (int i = 0; i < 1024; i++) ram[i] = 3'b000;
        repeat (3) @(negedge clock);
        check_eq("reset_outs", 32'({plot, busy, done, x, y, colour}), 32'd0);
        check_eq("reset_addr", 32'(mem_addr), 32'd0);
        resetn = 1'b1;

        // Reset during DRAW of slot 5 abandons the sweep
        ram[5] = 3'b010;
        build_expect(dc, dp);
        pulse_start();
        cnt = 0;
        while (!(plot && mem_addr == 10'd5) && cnt < 5000) begin
            @(negedge clock);
            cnt++;
        end
        check_eq("rst_reach_slot5", 32'(plot && mem_addr == 10'd5), 32'd1);
        resetn = 1'b0;
        @(negedge clock);
        check_eq("rst_outs", 32'({plot, busy, done}), 32'd0);
        check_eq("rst_pix", 32'({x, y, colour}), 32'd0);
        resetn = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clock);
        check_eq("rst_stays_idle", 32'({busy, done, plot}), 32'd0);
        ram[5] = 3'b000;

        // Single brick at slot 17
        ram[17] = 3'b100;
        run_sweep("single", -1, last);
        check_eq("single_last", 32'(last), 32'({10'd15, 10'd7, 3'b100}));

        // Empty grid
        ram[17] = 3'b000;
        run_sweep("empty", -1, last);
`ifdef ERASE_EMPTY_EN
        check_eq("empty_last", 32'(last), 32'({10'd127, 10'd31, 3'b000}));
`endif

        // Start re-pulsed mid-sweep must be ignored
        ram[17] = 3'b100;
        run_sweep("restart", 10, last);
        check_eq("restart_last", 32'(last), 32'({10'd15, 10'd7, 3'b100}));

        // Full grid of random non-empty colours
        for (int s = 0; s < 128; s++) ram[s] = 3'($urandom_range(1, 7));
        ram[127] = 3'b011;
        run_sweep("full", -1, last);
        check_eq("full_last", 32'(last), 32'({10'd127, 10'd31, 3'b011}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
